// File: rtl/i2c_rx_fifo_if.sv
// Bus between the RX byte FIFO and its two clients: I2C deserializer (push) and APB register block (pop/status).
// Optional almost_full signal is present only when RX_FIFO_ALMOST_FULL_EN is defined.
interface i2c_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  flush;
  logic                  clr_flags;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
`ifdef RX_FIFO_ALMOST_FULL_EN
  logic                  almost_full;
`endif

  modport master (
    output wr_en, wr_data, rd_en, flush, clr_flags,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
`ifdef RX_FIFO_ALMOST_FULL_EN
    , input almost_full
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_flags,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
`ifdef RX_FIFO_ALMOST_FULL_EN
    , output almost_full
`endif
  );
endinterface

// File: rtl/i2c_rx_fifo.sv
// I2C receive byte FIFO in the PCLK domain with registered pop data and sticky error flags.
// Define RX_FIFO_ALMOST_FULL_EN to add the AFULL_LEVEL parameter and almost_full output.
module i2c_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 3
`ifdef RX_FIFO_ALMOST_FULL_EN
  , parameter int AFULL_LEVEL = DEPTH - 2
`endif
) (
  input logic          PCLK,
  input logic          PRESETn,
  i2c_rx_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic full_w;
  logic empty_w;
  logic push_ok;
  logic pop_ok;
  logic ovf_evt;
  logic unf_evt;

  assign full_w  = (count_reg == DEPTH_CNT);
  assign empty_w = (count_reg == '0);

  // A pop frees the slot a push into a full FIFO lands in, so rd_en unblocks a full write.
  assign push_ok = bus.wr_en && (!full_w || bus.rd_en) && !bus.flush;
  assign pop_ok  = bus.rd_en && !empty_w && !bus.flush;
  assign ovf_evt = bus.wr_en && full_w && !bus.rd_en && !bus.flush;
  assign unf_evt = bus.rd_en && empty_w && !bus.flush;

  always_comb begin
    count_next = count_reg;
    if (bus.flush) begin
      count_next = '0;
    end else if (push_ok && !pop_ok) begin
      count_next = count_reg + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge PCLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      rd_valid_reg <= pop_ok;

      if (bus.flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop_ok) begin
          rd_ptr_reg  <= rd_ptr_reg + 1'b1;
          rd_data_reg <= mem[rd_ptr_reg];
        end
      end

      // A new error in the same cycle as clr_flags keeps the flag set.
      if (ovf_evt) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_flags) begin
        overflow_reg <= 1'b0;
      end

      if (unf_evt) begin
        underflow_reg <= 1'b1;
      end else if (bus.clr_flags) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.count     = count_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;

`ifdef RX_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  assign bus.almost_full = (count_reg >= AFULL_CNT);
`endif

endmodule
